pcs_40g_rx_block_sync: RTL
==========================

Name: pcs_40g_rx_block_sync

Overview:
Receive-side counterpart of the 40GBASE-R PCS transmit path. Per-lane 64b/66b block synchronizer (IEEE 802.3 Cl.82 block-lock state machine). It sits between the per-lane RX gearbox, which presents 66-bit candidate blocks and accepts slip requests, and the downstream alignment-marker lock, deskew and descrambler stages. It asserts per-lane and aggregate block lock and forwards registered blocks tagged with lock status.

Parameters:
LANE_N, 4, number of PCS lanes
DATA_W, 64, payload bits per block per lane
HEAD_W, 2, sync header bits per block
LOCK_CNT, 64, consecutive valid headers required to gain lock
INVLD_MAX, 16, invalid headers within a LOCK_CNT window that drop lock
SLIP_WAIT, 2, cycles after a slip during which incoming blocks are ignored (gearbox realignment latency)

Ports:
clk  in  1  single clock for the whole block
reset  in  1  synchronous, active-high reset
valid_i  in  LANE_N  per-lane candidate block valid from gearbox
head_i  in  LANE_N*HEAD_W  per-lane sync header, lane i at [i*HEAD_W +: HEAD_W]
data_i  in  LANE_N*DATA_W  per-lane 64-bit payload, still scrambled
slip_o  out  LANE_N  one-cycle pulse; gearbox shifts its 66-bit boundary by 1 bit
lock_o  out  LANE_N  per-lane block_lock
all_lock_o  out  1  AND of lock_o
valid_o  out  LANE_N  registered valid_i, gated to 0 during SLIP_WAIT
head_o  out  LANE_N*HEAD_W  registered head_i
data_o  out  LANE_N*DATA_W  registered data_i

Behaviour:
- One clock; reset is synchronous and active-high. All state updates on posedge clk.
- Reset: slip_o=0, lock_o=0, all_lock_o=0, valid_o=0, head_o=0, data_o=0. Counters cleared. Each lane FSM goes to RESET_CNT.
- A header is valid when it is 2'b01 or 2'b10. 2'b00 and 2'b11 are invalid.
- Lanes are fully independent. The only cross-lane logic is all_lock_o.
- Per-lane counters:
  - sh_cnt: 0..LANE-sized to count to LOCK_CNT, i.e. $clog2(LOCK_CNT+1) bits.
  - sh_invld_cnt: 0..INVLD_MAX.
  - slip_wait_cnt: 0..SLIP_WAIT.
- FSM states:
  - RESET_CNT: clear sh_cnt and sh_invld_cnt, then go to TEST_SH. This takes 1 cycle; input in this cycle is not tested.
  - TEST_SH: wait for valid_i[i]. Each valid block increments sh_cnt.
    - Valid header: if sh_cnt+1==LOCK_CNT and sh_invld_cnt==0, set lock and go to RESET_CNT. If sh_cnt+1==LOCK_CNT and sh_invld_cnt>0, go to RESET_CNT and keep lock unchanged. Otherwise stay in TEST_SH.
    - Invalid header, lock_o=0: go to SLIP.
    - Invalid header, lock_o=1: increment sh_invld_cnt. If the new value == INVLD_MAX, clear lock and go to SLIP. Else if sh_cnt+1==LOCK_CNT, go to RESET_CNT. Else stay.
  - SLIP: assert slip_o[i] for exactly 1 cycle, clear lock, load slip_wait_cnt=SLIP_WAIT, go to SLIP_WAIT.
  - SLIP_WAIT: ignore valid_i and force valid_o[i]=0. Decrement each cycle. At 0, go to RESET_CNT.
- lock_o is a register. It changes the cycle after the deciding block is sampled.
- all_lock_o is registered at the same stage as lock_o, so it has no extra cycle of skew.
- Data path latency is 1 cycle: valid_o/head_o/data_o show the block sampled on the previous edge. Its lock status appears on lock_o at the same edge as the block is decided.
- head_o/data_o hold their last value when valid_o=0.
- Boundaries:
  - A valid_i gap (valid_i=0) freezes the FSM and counters.
  - Reset mid-operation aborts a slip pulse or wait at the next edge.
  - Counters never wrap: sh_cnt resets at LOCK_CNT and sh_invld_cnt saturates at INVLD_MAX.
  - Slip is never issued in two consecutive cycles on the same lane.

Decomposition:
- Shared package pcs_rx_pkg:
  - SYNC_HEAD_DATA=2'b01, SYNC_HEAD_CTRL=2'b10
  - block-lock FSM enum typedef {RESET_CNT, TEST_SH, SLIP, SLIP_WAIT}
  - default LOCK_CNT/INVLD_MAX constants
- Natural sub-module: pcs_block_lock_lane, one lane's FSM, counters and output register. The top module instantiates LANE_N copies in a generate loop and ANDs the lock outputs.

Test Plan:
- Reset, then 64 consecutive valid blocks on all lanes with head 2'b01 → lock_o=4'b1111 and all_lock_o=1 on the cycle after the 64th block; no slip_o.
- Lane 2 receives head 2'b11 on block 10 while unlocked → slip_o[2] pulses for 1 cycle; valid_o[2]=0 for 2 cycles; then the count restarts and lock occurs 64 valid blocks later. Other lanes are unaffected.
- Locked lane 0 receives 15 invalid headers within a 64-block window → lock stays 1 and sh_invld_cnt clears at the window end. 16 invalid headers in a window → lock_o[0] falls, with one slip_o[0] pulse.
- Random valid_i gaps (every 3rd cycle low) with 64 valid blocks → lock asserts after exactly 64 valid samples, regardless of elapsed cycles.
- reset asserted the cycle slip_o[1]=1 → at the next edge slip_o=0, lock_o=0, valid_o=0, and the FSM is in RESET_CNT.
- data_i=64'hDEADBEEF_00000001, head_i=2'b10 with valid → identical values on data_o/head_o exactly 1 cycle later.

Source files
------------

// File: rtl/pcs_rx_pkg.sv
// Shared constants, block-lock state type and sync-header helper for the 40G PCS receive path.
package pcs_rx_pkg;

    localparam logic [1:0] SYNC_HEAD_DATA = 2'b01;
    localparam logic [1:0] SYNC_HEAD_CTRL = 2'b10;

    localparam int unsigned DEF_LOCK_CNT  = 64;
    localparam int unsigned DEF_INVLD_MAX = 16;
    localparam int unsigned DEF_SLIP_WAIT = 2;

    typedef enum logic [1:0] {
        ST_RESET_CNT,
        ST_TEST_SH,
        ST_SLIP,
        ST_SLIP_WAIT
    } blk_lock_state_e;

    // Only the two data/control headers are legal; 00 and 11 mark a misaligned boundary.
    function automatic logic is_sync_head(input logic [1:0] head);
        return (head == SYNC_HEAD_DATA) || (head == SYNC_HEAD_CTRL);
    endfunction

endpackage

// File: rtl/pcs_block_lock_lane.sv
// One lane of the 64b/66b block synchronizer: block-lock FSM, header counters and
// the registered block/lock outputs.
module pcs_block_lock_lane
    import pcs_rx_pkg::*;
#(
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned HEAD_W    = 2,
    parameter int unsigned LOCK_CNT  = DEF_LOCK_CNT,
    parameter int unsigned INVLD_MAX = DEF_INVLD_MAX,
    parameter int unsigned SLIP_WAIT = DEF_SLIP_WAIT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_i,
    input  logic [HEAD_W-1:0] head_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              slip_o,
    output logic              lock_o,
    output logic              lock_nxt_c,
    output logic              valid_o,
    output logic [HEAD_W-1:0] head_o,
    output logic [DATA_W-1:0] data_o
);

    localparam int unsigned CNT_W  = $clog2(LOCK_CNT + 1);
    localparam int unsigned INV_W  = $clog2(INVLD_MAX + 1);
    localparam int unsigned WAIT_W = (SLIP_WAIT < 1) ? 1 : $clog2(SLIP_WAIT + 1);

    blk_lock_state_e    r_state;
    logic [CNT_W-1:0]   r_sh_cnt;
    logic [INV_W-1:0]   r_invld_cnt;
    logic [WAIT_W-1:0]  r_wait_cnt;
    logic               r_slip;
    logic               r_lock;
    logic               r_valid;
    logic [HEAD_W-1:0]  r_head;
    logic [DATA_W-1:0]  r_data;

    logic w_test;
    logic w_hdr_ok;
    logic w_cnt_last;
    logic w_invld_last;
    logic w_pass;
    logic w_lock_nxt;

    // Decode of the current sample; lock_nxt is exported so the aggregate lock lines up with lock_o.
    always_comb begin
        w_test       = (r_state == ST_TEST_SH) && valid_i;
        w_hdr_ok     = is_sync_head(head_i[1:0]);
        w_cnt_last   = (r_sh_cnt == CNT_W'(LOCK_CNT - 1));
        w_invld_last = (r_invld_cnt == INV_W'(INVLD_MAX - 1));
        w_pass       = valid_i && (r_state != ST_SLIP_WAIT);
        w_lock_nxt   = r_lock;
        if (r_state == ST_SLIP) begin
            w_lock_nxt = 1'b0;
        end else if (w_test) begin
            if (w_hdr_ok) begin
                if (w_cnt_last && (r_invld_cnt == '0)) begin
                    w_lock_nxt = 1'b1;
                end
            end else if (w_invld_last) begin
                w_lock_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_RESET_CNT;
            r_sh_cnt    <= '0;
            r_invld_cnt <= '0;
            r_wait_cnt  <= '0;
            r_slip      <= 1'b0;
            r_lock      <= 1'b0;
            r_valid     <= 1'b0;
            r_head      <= '0;
            r_data      <= '0;
        end else begin
            r_lock  <= w_lock_nxt;
            r_slip  <= 1'b0;
            r_valid <= w_pass;
            if (w_pass) begin
                r_head <= head_i;
                r_data <= data_i;
            end
            case (r_state)
                ST_RESET_CNT: begin
                    r_sh_cnt    <= '0;
                    r_invld_cnt <= '0;
                    r_state     <= ST_TEST_SH;
                end
                ST_TEST_SH: begin
                    // A valid_i gap leaves the state and both counters untouched.
                    if (valid_i) begin
                        if (w_hdr_ok) begin
                            if (w_cnt_last) begin
                                r_state <= ST_RESET_CNT;
                            end else begin
                                r_sh_cnt <= r_sh_cnt + CNT_W'(1);
                            end
                        end else if (!r_lock || w_invld_last) begin
                            r_slip  <= 1'b1;
                            r_state <= ST_SLIP;
                            if (r_lock) begin
                                r_invld_cnt <= r_invld_cnt + INV_W'(1);
                            end
                        end else begin
                            r_invld_cnt <= r_invld_cnt + INV_W'(1);
                            if (w_cnt_last) begin
                                r_state <= ST_RESET_CNT;
                            end else begin
                                r_sh_cnt <= r_sh_cnt + CNT_W'(1);
                            end
                        end
                    end
                end
                ST_SLIP: begin
                    r_wait_cnt <= WAIT_W'(SLIP_WAIT);
                    r_state    <= ST_SLIP_WAIT;
                end
                ST_SLIP_WAIT: begin
                    // Gearbox is realigning; blocks seen here are discarded.
                    if (r_wait_cnt <= WAIT_W'(1)) begin
                        r_wait_cnt <= '0;
                        r_state    <= ST_RESET_CNT;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - WAIT_W'(1);
                    end
                end
                default: r_state <= ST_RESET_CNT;
            endcase
        end
    end

    assign slip_o     = r_slip;
    assign lock_o     = r_lock;
    assign lock_nxt_c = w_lock_nxt;
    assign valid_o    = r_valid;
    assign head_o     = r_head;
    assign data_o     = r_data;

endmodule

// File: rtl/pcs_40g_rx_block_sync.sv
// 40GBASE-R receive block synchronizer: independent per-lane block lock plus an
// aggregate lock registered at the same stage as the per-lane locks.
module pcs_40g_rx_block_sync
    import pcs_rx_pkg::*;
#(
    parameter int unsigned LANE_N    = 4,
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned HEAD_W    = 2,
    parameter int unsigned LOCK_CNT  = DEF_LOCK_CNT,
    parameter int unsigned INVLD_MAX = DEF_INVLD_MAX,
    parameter int unsigned SLIP_WAIT = DEF_SLIP_WAIT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [LANE_N-1:0]          valid_i,
    input  logic [LANE_N*HEAD_W-1:0]   head_i,
    input  logic [LANE_N*DATA_W-1:0]   data_i,
    output logic [LANE_N-1:0]          slip_o,
    output logic [LANE_N-1:0]          lock_o,
    output logic                       all_lock_o,
    output logic [LANE_N-1:0]          valid_o,
    output logic [LANE_N*HEAD_W-1:0]   head_o,
    output logic [LANE_N*DATA_W-1:0]   data_o
);

    logic [LANE_N-1:0] w_lock_nxt;
    logic              r_all_lock;

    for (genvar g = 0; g < LANE_N; g++) begin : g_lane
        pcs_block_lock_lane #(
            .DATA_W    (DATA_W),
            .HEAD_W    (HEAD_W),
            .LOCK_CNT  (LOCK_CNT),
            .INVLD_MAX (INVLD_MAX),
            .SLIP_WAIT (SLIP_WAIT)
        ) u_lane (
            .clk        (clk),
            .reset      (reset),
            .valid_i    (valid_i[g]),
            .head_i     (head_i[g*HEAD_W +: HEAD_W]),
            .data_i     (data_i[g*DATA_W +: DATA_W]),
            .slip_o     (slip_o[g]),
            .lock_o     (lock_o[g]),
            .lock_nxt_c (w_lock_nxt[g]),
            .valid_o    (valid_o[g]),
            .head_o     (head_o[g*HEAD_W +: HEAD_W]),
            .data_o     (data_o[g*DATA_W +: DATA_W])
        );
    end

    // Built from the lanes' next-lock values so it updates on the same edge as lock_o.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_all_lock <= 1'b0;
        end else begin
            r_all_lock <= &w_lock_nxt;
        end
    end

    assign all_lock_o = r_all_lock;

endmodule
